gpio_amm_csr: RTL and testbench
===============================

Name: gpio_amm_csr

Overview:
- Avalon-MM slave register block that configures and sequences one GPIO bank: output data, output enable, synchronised input sampling and per-pin edge capture.
- Sits between the system interconnect and the pad-level tristate logic, which consumes gpio_o/gpio_oe_o and returns gpio_i.
- Single clock domain.
- gpio_i is asynchronous and is resynchronised inside this block.

Parameters:
- AMM_WIDTH, 32, Avalon data width in bits; must be >= GPIO_WIDTH.
- GPIO_WIDTH, 8, number of GPIO pins (1..AMM_WIDTH).

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  synchronous reset, active-low.
- amm_address_i  input  3  word address.
- amm_write_i  input  1  write strobe.
- amm_writedata_i  input  AMM_WIDTH  write data.
- amm_read_i  input  1  read strobe.
- amm_readdata_o  output  AMM_WIDTH  read data.
- amm_readdatavalid_o  output  1  read data valid.
- gpio_o  output  GPIO_WIDTH  pad output data.
- gpio_oe_o  output  GPIO_WIDTH  pad output enable, 1 = drive.
- gpio_i  input  GPIO_WIDTH  pad input, asynchronous.
- irq_o  output  1  level interrupt.

Behaviour:
- Reset: clk_i edge with rst_i=0 clears every register, synchroniser and edge flop. All outputs read 0 (gpio_o, gpio_oe_o, amm_readdata_o, amm_readdatavalid_o, irq_o); all pins are inputs.
- Address map (word addresses):
  - 0 OUT: rw.
  - 1 OE: rw.
  - 2 IN: ro, synchronised pin state.
  - 3 OUT_SET: wo, 1-bits set OUT; reads 0.
  - 4 OUT_CLR: wo, 1-bits clear OUT; reads 0.
  - 5 EDGE_STAT: rw1c.
  - 6 RISE_EN: rw.
  - 7 FALL_EN: rw.
- Width rules: bits [AMM_WIDTH-1:GPIO_WIDTH] read 0 and ignore writes.
- Writes: take effect on the clk_i edge where amm_write_i=1. gpio_o/gpio_oe_o update at that edge (zero extra latency).
- Reads: fixed latency 1. amm_read_i at edge N gives amm_readdatavalid_o=1 with data for one cycle after edge N+1; no waitrequest; back-to-back reads each cycle are allowed.
- Read and write in the same cycle: read returns the pre-write value; the write still lands.
- Input path: 2-flop synchroniser (s1, s2) plus history flop s3. IN = s2. A pin change is visible in IN two edges after it is sampled.
- Edge detection:
  - rise[i] = s2[i] & ~s3[i] & RISE_EN[i]
  - fall[i] = ~s2[i] & s3[i] & FALL_EN[i]
  - EDGE_STAT[i] sets on rise[i] | fall[i] and stays set until cleared.
- W1C: writing 1 to EDGE_STAT[i] clears it. If an edge event and a W1C on the same bit occur in the same cycle, set wins.
- Enable changes: RISE_EN/FALL_EN changes apply from the next edge. Disabling does not clear already-latched status.
- Loopback: driven pins still pass through the synchroniser, so a pin driven by OE/OUT is observable on IN and can raise edges.
- Reset mid-operation: a pending read is dropped (no readdatavalid) and all state clears. The first edge after reset release cannot create an edge event, because s3 and s2 are both 0 and a pin that is already 1 is only seen after synchronisation.
- Illegal strobes: amm_read_i and amm_write_i on a write-only register give read data 0, no error.

Optional Feature:
- Macro: GPIO_CSR_IRQ_EN.
- Defined:
  - Address 6/7 edge logic is active.
  - EDGE_STAT is implemented.
  - irq_o = |EDGE_STAT, registered: asserts one edge after the status bit sets and deasserts one edge after the last bit is cleared.
- Undefined:
  - Addresses 5, 6 and 7 read 0 and ignore writes.
  - No edge flops are synthesised.
  - irq_o tied to 0.
  - All other behaviour unchanged.

Test Plan:
- Reset values: hold rst_i=0 3 cycles with gpio_i=8'hFF, release → gpio_o=0, gpio_oe_o=0, irq_o=0; read addr 2 at the 3rd post-reset edge → 8'hFF.
- Output registers: write OUT=8'hA5, then OE=8'h0F → gpio_o=8'hA5, gpio_oe_o=8'h0F the cycle after each write. Then OUT_SET=8'h50 → OUT=8'hF5; then OUT_CLR=8'h81 → OUT=8'h74; read addr 3 → 0.
- Read timing: reads on 4 consecutive cycles of addrs 0,1,2,0 → 4 consecutive valid pulses, each one cycle after its request, in order. Read and write OUT=8'h3C in the same cycle → read returns the old value, a later read returns 8'h3C.
- Rising edge (macro defined): RISE_EN=8'h01, gpio_i[0] 0→1 at edge N → EDGE_STAT=8'h01 after edge N+3, irq_o=1 after N+4. Write 1 to addr 5 → status 0, irq_o drops the next cycle.
- Set-wins collision: toggle gpio_i[1] with FALL_EN[1]=1 so the fall event coincides with a W1C of bit 1 → EDGE_STAT[1] stays 1.
- Macro undefined: same stimulus as the rising-edge scenario → addr 5 reads 0, irq_o stays 0; reset asserted mid-read → no readdatavalid.

Source files
------------

// File: rtl/gpio_amm_csr.sv
// Avalon-MM CSR block for one GPIO bank: output/enable registers, synchronised input, edge capture.
// Edge capture and irq_o are built only when GPIO_CSR_IRQ_EN is defined.
module gpio_amm_csr #(
  parameter int AMM_WIDTH  = 32,
  parameter int GPIO_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [2:0]            amm_address_i,
  input  logic                  amm_write_i,
  input  logic [AMM_WIDTH-1:0]  amm_writedata_i,
  input  logic                  amm_read_i,
  output logic [AMM_WIDTH-1:0]  amm_readdata_o,
  output logic                  amm_readdatavalid_o,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic                  irq_o
);
  localparam logic [2:0] A_OUT  = 3'd0;
  localparam logic [2:0] A_OE   = 3'd1;
  localparam logic [2:0] A_IN   = 3'd2;
  localparam logic [2:0] A_SET  = 3'd3;
  localparam logic [2:0] A_CLR  = 3'd4;
  localparam logic [2:0] A_STAT = 3'd5;
  localparam logic [2:0] A_RISE = 3'd6;
  localparam logic [2:0] A_FALL = 3'd7;

  logic [GPIO_WIDTH-1:0] out_q, out_d, oe_q, oe_d, s1_q, s2_q;
  logic [GPIO_WIDTH-1:0] wdat, rsel;
  logic [GPIO_WIDTH-1:0] stat_v, rise_v, fall_v;
  logic [AMM_WIDTH-1:0]  rdata_q;
  logic                  rvalid_q;
  logic                  unused_wd;

  // Bits above GPIO_WIDTH are ignored on write.
  assign wdat      = amm_writedata_i[GPIO_WIDTH-1:0];
  assign unused_wd = ^amm_writedata_i;

  always_comb begin
    out_d = out_q;
    oe_d  = oe_q;
    if (amm_write_i) begin
      case (amm_address_i)
        A_OUT:   out_d = wdat;
        A_OE:    oe_d  = wdat;
        A_SET:   out_d = out_q | wdat;
        A_CLR:   out_d = out_q & ~wdat;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      out_q <= '0;
      oe_q  <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      out_q <= out_d;
      oe_q  <= oe_d;
      s1_q  <= gpio_i;
      s2_q  <= s1_q;
    end
  end

`ifdef GPIO_CSR_IRQ_EN
  logic [GPIO_WIDTH-1:0] s3_q, stat_q, stat_d, rise_en_q, fall_en_q, ev, w1c;
  logic                  irq_q;

  assign ev  = (s2_q & ~s3_q & rise_en_q) | (~s2_q & s3_q & fall_en_q);
  assign w1c = (amm_write_i && amm_address_i == A_STAT) ? wdat : '0;
  // New events are OR-ed in after the clear so a coincident event wins.
  assign stat_d = (stat_q & ~w1c) | ev;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      s3_q      <= '0;
      stat_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      s3_q   <= s2_q;
      stat_q <= stat_d;
      irq_q  <= |stat_q;
      if (amm_write_i && amm_address_i == A_RISE) rise_en_q <= wdat;
      if (amm_write_i && amm_address_i == A_FALL) fall_en_q <= wdat;
    end
  end

  assign stat_v = stat_q;
  assign rise_v = rise_en_q;
  assign fall_v = fall_en_q;
  assign irq_o  = irq_q;
`else
  assign stat_v = '0;
  assign rise_v = '0;
  assign fall_v = '0;
  assign irq_o  = 1'b0;
`endif

  always_comb begin
    rsel = '0;
    case (amm_address_i)
      A_OUT:   rsel = out_q;
      A_OE:    rsel = oe_q;
      A_IN:    rsel = s2_q;
      A_STAT:  rsel = stat_v;
      A_RISE:  rsel = rise_v;
      A_FALL:  rsel = fall_v;
      default: rsel = '0;
    endcase
  end

  // Capturing current register values gives pre-write data on a same-cycle read/write.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= amm_read_i ? AMM_WIDTH'(rsel) : '0;
      rvalid_q <= amm_read_i;
    end
  end

  assign amm_readdata_o      = rdata_q;
  assign amm_readdatavalid_o = rvalid_q;
  assign gpio_o              = out_q;
  assign gpio_oe_o           = oe_q;
endmodule

// File: tb/tb_gpio_amm_csr.sv
// Directed bench for gpio_amm_csr; expectations follow GPIO_CSR_IRQ_EN when it is defined.
module tb_gpio_amm_csr;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  addr;
  logic        wr, rd;
  logic [31:0] wdata, rdata;
  logic        rvld;
  logic [7:0]  gpo, gpoe, gpi;
  logic        irq;
  int          nvec = 0;
  int          nbad = 0;

`ifdef GPIO_CSR_IRQ_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  always #5 clk = ~clk;

  gpio_amm_csr #(.AMM_WIDTH(32), .GPIO_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst_n), .amm_address_i(addr), .amm_write_i(wr),
    .amm_writedata_i(wdata), .amm_read_i(rd), .amm_readdata_o(rdata),
    .amm_readdatavalid_o(rvld), .gpio_o(gpo), .gpio_oe_o(gpoe), .gpio_i(gpi),
    .irq_o(irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic amm_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic amm_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr = a; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    chk({tag, ".vld"}, {31'd0, rvld}, 32'd1);
    chk(tag, rdata, exp);
  endtask

  logic [2:0]  ra [4];
  logic [31:0] re [4];

  initial begin
    rst_n = 1'b0; addr = '0; wr = 1'b0; rd = 1'b0; wdata = '0; gpi = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.gpio_o", {24'd0, gpo}, 32'd0);
    chk("rst.gpio_oe", {24'd0, gpoe}, 32'd0);
    chk("rst.irq", {31'd0, irq}, 32'd0);
    chk("rst.rvld", {31'd0, rvld}, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    amm_rd("rst.in", 3'd2, 32'hFF);
    gpi = 8'h5A;

    amm_wr(3'd0, 32'hFFFF_FFA5); chk("out.wr", {24'd0, gpo}, 32'hA5);
    amm_wr(3'd1, 32'h0000_000F); chk("oe.wr", {24'd0, gpoe}, 32'h0F);
    amm_wr(3'd3, 32'h50);        chk("out.set", {24'd0, gpo}, 32'hF5);
    amm_wr(3'd4, 32'h81);        chk("out.clr", {24'd0, gpo}, 32'h74);
    amm_rd("rd.set", 3'd3, 32'd0);
    amm_rd("rd.clr", 3'd4, 32'd0);
    amm_rd("rd.out_hi", 3'd0, 32'h74);

    ra[0] = 3'd0; ra[1] = 3'd1; ra[2] = 3'd2; ra[3] = 3'd0;
    re[0] = 32'h74; re[1] = 32'h0F; re[2] = 32'h5A; re[3] = 32'h74;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      addr = ra[i]; rd = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("b2b%0d.vld", i), {31'd0, rvld}, 32'd1);
      chk($sformatf("b2b%0d", i), rdata, re[i]);
    end
    @(negedge clk); rd = 1'b0;
    @(posedge clk); #1;
    chk("b2b.idle", {31'd0, rvld}, 32'd0);

    @(negedge clk);
    addr = 3'd0; rd = 1'b1; wr = 1'b1; wdata = 32'h3C;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    chk("rw.old", rdata, 32'h74);
    chk("rw.out", {24'd0, gpo}, 32'h3C);
    amm_rd("rw.new", 3'd0, 32'h3C);

    amm_wr(3'd6, 32'h01);
    amm_wr(3'd7, 32'h02);
    amm_rd("rise_en", 3'd6, EDGE ? 32'h01 : 32'h0);
    @(negedge clk); gpi = 8'h5B;
    repeat (3) @(posedge clk);
    #1;
    chk("rise.irq_n3", {31'd0, irq}, 32'd0);
    amm_rd("rise.stat", 3'd5, EDGE ? 32'h01 : 32'h0);
    chk("rise.irq_n4", {31'd0, irq}, {31'd0, EDGE});
    amm_rd("rise.in", 3'd2, 32'h5B);
    amm_wr(3'd5, 32'h01);
    chk("w1c.irq_hold", {31'd0, irq}, {31'd0, EDGE});
    @(posedge clk); #1;
    chk("w1c.irq_drop", {31'd0, irq}, 32'd0);
    amm_rd("w1c.stat", 3'd5, 32'd0);

    @(negedge clk); gpi = 8'h59;
    repeat (2) @(posedge clk);
    amm_wr(3'd5, 32'h02);
    amm_rd("coll.stat", 3'd5, EDGE ? 32'h02 : 32'h0);
    chk("coll.irq", {31'd0, irq}, {31'd0, EDGE});
    amm_wr(3'd5, 32'h02);
    amm_rd("coll.clr", 3'd5, 32'd0);

    @(negedge clk);
    addr = 3'd0; rd = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    rd = 1'b0;
    chk("rstrd.vld", {31'd0, rvld}, 32'd0);
    chk("rstrd.gpio_o", {24'd0, gpo}, 32'd0);
    @(posedge clk); #1;
    chk("rstrd.vld2", {31'd0, rvld}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    amm_rd("rstrd.out", 3'd0, 32'd0);
    amm_rd("rstrd.rise_en", 3'd6, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
